// File: rtl/dpram_port_scheduler.sv
// Round-robin scheduler sharing one dual-port RAM among N_REQ requesters, two grants per cycle.
// Optional build macro SCHED_STATS_EN adds the saturating conflict_cnt output.
module dpram_port_scheduler #(
    parameter int N_REQ = 4,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [N_REQ*AW-1:0]  req_addr,
    input  logic [N_REQ*DW-1:0]  req_wdata,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [N_REQ*DW-1:0]  rsp_data,
    output logic [AW-1:0]        addr_a,
    output logic [AW-1:0]        addr_b,
    output logic                 read_a,
    output logic                 read_b,
    output logic                 write_a,
    output logic                 write_b,
    output logic [DW-1:0]        write_data_a,
    output logic [DW-1:0]        write_data_b,
    input  logic [DW-1:0]        read_data_a,
    input  logic [DW-1:0]        read_data_b
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]          conflict_cnt
`endif
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [PW:0]   N_W  = (PW+1)'(N_REQ);
    localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

    logic [AW-1:0] addr_v  [N_REQ];
    logic [DW-1:0] wdata_v [N_REQ];

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] sel_a;
    logic [PW-1:0] sel_b;
    logic          found_a;
    logic          found_b;
`ifdef SCHED_STATS_EN
    logic          skipped;
`endif

    // Tags: stage 1 travels with the RAM strobes, stage 2 with the returning read data.
    logic [PW-1:0] tag_a;
    logic [PW-1:0] tag_b;
    logic [PW-1:0] tag2_a;
    logic [PW-1:0] tag2_b;
    logic          busy2_a;
    logic          busy2_b;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_v[g]  = req_addr[g*AW +: AW];
        assign wdata_v[g] = req_wdata[g*DW +: DW];
    end

    // Scan from rr_ptr; the first valid takes port A, the first non-conflicting later one takes B.
    always_comb begin
        logic [PW:0]   pos;
        logic [PW-1:0] idx;
        found_a = 1'b0;
        found_b = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        pos     = '0;
        idx     = '0;
`ifdef SCHED_STATS_EN
        skipped = 1'b0;
`endif
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (PW+1)'(k);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end
            idx = pos[PW-1:0];
            if (req_valid[idx]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    sel_a   = idx;
                end else if (!found_b) begin
                    if (addr_v[idx] == addr_v[sel_a] && (req_we[idx] || req_we[sel_a])) begin
`ifdef SCHED_STATS_EN
                        skipped = 1'b1;
`endif
                    end else begin
                        found_b = 1'b1;
                        sel_b   = idx;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_out
        assign req_ready[g] = !reset && ((found_a && sel_a == PW'(g)) || (found_b && sel_b == PW'(g)));
        assign rsp_valid[g] = (busy2_a && tag2_a == PW'(g)) || (busy2_b && tag2_b == PW'(g));
        assign rsp_data[g*DW +: DW] = (busy2_a && tag2_a == PW'(g)) ? read_data_a :
                                      (busy2_b && tag2_b == PW'(g)) ? read_data_b : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            read_a       <= 1'b0;
            read_b       <= 1'b0;
            write_a      <= 1'b0;
            write_b      <= 1'b0;
            addr_a       <= '0;
            addr_b       <= '0;
            write_data_a <= '0;
            write_data_b <= '0;
            tag_a        <= '0;
            tag_b        <= '0;
            tag2_a       <= '0;
            tag2_b       <= '0;
            busy2_a      <= 1'b0;
            busy2_b      <= 1'b0;
        end else begin
            read_a  <= found_a && !req_we[sel_a];
            write_a <= found_a && req_we[sel_a];
            read_b  <= found_b && !req_we[sel_b];
            write_b <= found_b && req_we[sel_b];
            if (found_a) begin
                addr_a       <= addr_v[sel_a];
                write_data_a <= wdata_v[sel_a];
                tag_a        <= sel_a;
                rr_ptr       <= (sel_a == LAST) ? '0 : sel_a + 1'b1;
            end
            if (found_b) begin
                addr_b       <= addr_v[sel_b];
                write_data_b <= wdata_v[sel_b];
                tag_b        <= sel_b;
            end
            busy2_a <= read_a;
            busy2_b <= read_b;
            tag2_a  <= tag_a;
            tag2_b  <= tag_b;
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (skipped && conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule
